// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bit-serial logic sequencer and its 1-bit logic unit.
//   - op select constants (same encoding on the command port and on lu_chave)
//   - sequencer FSM state encoding
//   - golden_bit(): reference result of one logic-unit evaluation
package logic_unit_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } seq_state_e;

  function automatic logic golden_bit(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_logic_seq.sv
// Bit-serial driver for the external 1-bit programmable logic unit.
// A WIDTH-bit command (op, A, B) is accepted over valid/ready, streamed LSB-first into the
// logic unit one bit per clock, and the unit's result bits are collected into a WIDTH-bit
// word presented downstream over valid/ready.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   cmd_valid_i    command offered
//   cmd_ready_o    command accepted on cmd_valid_i & cmd_ready_o at a clock edge
//   cmd_op_i       op select: 00 OR, 01 NOR, 10 XOR, 11 XNOR
//   cmd_a_i        operand A
//   cmd_b_i        operand B
//   lu_a_o         current bit of A to the logic unit (0 outside SHIFT)
//   lu_b_o         current bit of B to the logic unit (0 outside SHIFT)
//   lu_chave_o     op select to the logic unit (0 outside SHIFT)
//   lu_result_i    logic unit output, combinational from lu_a_o/lu_b_o/lu_chave_o
//   res_valid_o    result word available
//   res_ready_i    downstream accepts the result on res_valid_o & res_ready_i
//   res_data_o     assembled result word, held after the handshake
//   busy_o         high whenever the FSM is not idle
//   chk_err_o      sticky: a result bit disagreed with the locally computed golden bit
module bit_serial_logic_seq
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic             lu_a_o,
  output logic             lu_b_o,
  output logic [1:0]       lu_chave_o,
  input  logic             lu_result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             busy_o,
  output logic             chk_err_o
);

  localparam int unsigned     IdxW    = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  seq_state_e       state_q;
  logic [IdxW-1:0]  idx_q;
  // Operand bits not yet presented to the logic unit; bit 0 is the next one.
  logic [WIDTH-2:0] a_rem_q;
  logic [WIDTH-2:0] b_rem_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_data_q;
  logic             cmd_ready_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             lu_a_q;
  logic             lu_b_q;
  logic [1:0]       lu_chave_q;
  logic             chk_err_q;

  logic [WIDTH-1:0] res_d;
  logic             golden;

  // Result word with the current logic-unit bit merged in at idx.
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = lu_result_i;
  end

  // The lu_* registers hold exactly the latched op and A[idx]/B[idx] during SHIFT.
  assign golden = golden_bit(lu_chave_q, lu_a_q, lu_b_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_rem_q     <= '0;
      b_rem_q     <= '0;
      res_q       <= '0;
      res_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lu_a_q      <= 1'b0;
      lu_b_q      <= 1'b0;
      lu_chave_q  <= 2'b00;
      chk_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            lu_a_q      <= cmd_a_i[0];
            lu_b_q      <= cmd_b_i[0];
            lu_chave_q  <= cmd_op_i;
            a_rem_q     <= cmd_a_i[WIDTH-1:1];
            b_rem_q     <= cmd_b_i[WIDTH-1:1];
            res_q       <= '0;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StShift;
          end
        end

        StShift: begin
          res_q <= res_d;
          // The stored bit is always the unit's answer; the golden bit only flags errors.
          if (lu_result_i != golden) begin
            chk_err_q <= 1'b1;
          end
          if (idx_q == IdxLast) begin
            res_data_q  <= res_d;
            res_valid_q <= 1'b1;
            lu_a_q      <= 1'b0;
            lu_b_q      <= 1'b0;
            lu_chave_q  <= 2'b00;
            state_q     <= StDone;
          end else begin
            idx_q   <= idx_q + 1'b1;
            lu_a_q  <= a_rem_q[0];
            lu_b_q  <= b_rem_q[0];
            a_rem_q <= a_rem_q >> 1;
            b_rem_q <= b_rem_q >> 1;
          end
        end

        StDone: begin
          // cmd_ready rises only after the handshake, so a waiting command is
          // taken on the following idle cycle.
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          lu_a_q      <= 1'b0;
          lu_b_q      <= 1'b0;
          lu_chave_q  <= 2'b00;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = busy_q;
  assign lu_a_o      = lu_a_q;
  assign lu_b_o      = lu_b_q;
  assign lu_chave_o  = lu_chave_q;
  assign chk_err_o   = chk_err_q;

endmodule

// File: tb/tb_bit_serial_logic_seq.sv
// Bench for bit_serial_logic_seq with an inline 1-bit logic unit in the loop.
// Stimulus pushes expected words into a queue; a monitor thread pops on each result
// handshake and compares data, chk_err and accept-to-valid latency.
module tb_bit_serial_logic_seq;
  import logic_unit_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         lu_a;
  logic         lu_b;
  logic [1:0]   lu_chave;
  logic         lu_result;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         busy;
  logic         chk_err;

  logic stuck = 1'b0;
  logic rr_rand = 1'b0;
  logic rr_hold = 1'b1;
  logic sticky = 1'b0;
  logic prev_v = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         chk;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // The logic unit, optionally replaced by a stuck-at-0 output.
  always_comb begin
    lu_result = 1'b0;
    if (!stuck) begin
      case (lu_chave)
        2'b00:   lu_result = lu_a | lu_b;
        2'b01:   lu_result = ~(lu_a | lu_b);
        2'b10:   lu_result = lu_a ^ lu_b;
        default: lu_result = ~(lu_a ^ lu_b);
      endcase
    end
  end

  bit_serial_logic_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .lu_a_o      (lu_a),
    .lu_b_o      (lu_b),
    .lu_chave_o  (lu_chave),
    .lu_result_i (lu_result),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .busy_o      (busy),
    .chk_err_o   (chk_err)
  );

  // Whole-word reference for one command.
  function automatic logic [W-1:0] ref_word(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", 32'(res_data), 32'd0);
    check("rst lu", 32'({lu_a, lu_b, lu_chave}), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst chk_err", 32'(chk_err), 32'd0);
  endtask

  // Offer a command, wait for acceptance, record the expectation. Returns at accept edge + 1.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int   n = 0;
    exp_t e;
    logic [W-1:0] w;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check("accept timeout", 32'd0, 32'd1);
    end else begin
      w = ref_word(op, a, b);
      if (stuck && w != '0) sticky = 1'b1;
      e.data = stuck ? '0 : w;
      e.chk  = sticky;
      e.acc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // Scribble the inputs: they must have been sampled on accept only.
    cmd_op = 2'($urandom);
    cmd_a  = W'($urandom);
    cmd_b  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(posedge clk);
        #1;
        res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_hold;
      end
      // Monitor
      forever begin
        exp_t e;
        @(negedge clk);
        if (res_valid === 1'b1 && prev_v !== 1'b1) begin
          if (exp_q.size() == 0) check("unexpected valid", 32'd1, 32'd0);
          else check("latency", 32'(cyc - exp_q[0].acc), 32'(W));
        end
        if (busy === 1'b0) check("lu idle zero", 32'({lu_a, lu_b, lu_chave}), 32'd0);
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(e.data));
            check("chk_err", 32'(chk_err), 32'(e.chk));
          end
        end
        prev_v = res_valid;
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // 1: asynchronous reset asserted mid-cycle
    #12;
    reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 2, 3: directed functional cases
    send(OP_OR, 8'hA5, 8'h0F);
    send(OP_XOR, 8'hA5, 8'h5A);
    send(OP_NOR, 8'h00, 8'h00);
    send(OP_XNOR, 8'hFF, 8'h0F);
    wait_idle();

    // 4: backpressure in DONE with a competing command offered
    begin
      logic [W-1:0] held;
      int n = 0;
      rr_hold = 1'b0;
      send(OP_XOR, 8'h3C, 8'h66);
      @(negedge clk);
      while (!res_valid && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("bp valid seen", 32'(res_valid), 32'd1);
      held = res_data;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = OP_OR;
        cmd_a     = 8'h12;
        cmd_b     = 8'h40;
        @(negedge clk);
        check("bp res_valid", 32'(res_valid), 32'd1);
        check("bp res_data stable", 32'(res_data), 32'(held));
        check("bp cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rr_hold = 1'b1;
      send(OP_OR, 8'h12, 8'h40);
      wait_idle();
    end

    // 5: reset pulsed during SHIFT at idx=3
    send(OP_XNOR, W'($urandom), W'($urandom));
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    sticky = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    send(OP_OR, 8'h01, 8'h80);
    wait_idle();

    // Randomized commands with random backpressure and idle gaps
    rr_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(2'($urandom), W'($urandom), W'($urandom));
    end
    rr_rand = 1'b0;
    rr_hold = 1'b1;
    wait_idle();

    // 6: stuck-at-0 logic unit, then a healthy command with chk_err still set
    stuck = 1'b1;
    send(OP_OR, 8'hFF, W'($urandom));
    wait_idle();
    stuck = 1'b0;
    send(OP_XOR, 8'hC3, 8'h18);
    wait_idle();
    check("chk_err sticky", 32'(chk_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
